instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction prefetch: fetches words from a combinational RAM into a small {pc, word} queue.
// Latency: a word fetched at one edge is presented at the queue head from the next cycle.
// Backpressure: instr_ready low lets the queue fill, then fetching stalls until a slot frees.
module instr_fetch #(
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned MEM_BYTES = 800,
   parameter int unsigned DEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_read_data,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        fault
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam int          IW      = $clog2(DEPTH);
   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);

   typedef enum logic {RUN, FAULT} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_word [DEPTH];
   logic [CW-1:0] count;
   logic          fetch_ok;
   logic          push;
   logic          pop;
   logic          flush;
   logic [IW-1:0] wr_idx;

   // Entry 0 is always the head, so outputs come straight from registers.
   assign mem_address = fetch_pc;
   assign fetch_ok    = (fetch_pc <= LAST_PC);
   assign instr_valid = (count != '0);
   assign instr       = q_word[0];
   assign instr_pc    = q_pc[0];
   assign fault       = (state == FAULT);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Next state and queue control; a branch beats any push or pop that cycle.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      if (branch_valid) begin
         flush     = 1'b1;
         state_nxt = RUN;
      end else begin
         pop = instr_valid && instr_ready;
         if (state == RUN) begin
            if (fetch_ok) push = (count < FULL) || pop;
            else          state_nxt = FAULT;
         end
      end
   end

   // With a simultaneous pop the entries shift down first, so the new word lands one slot lower.
   always_comb begin
      wr_idx = IW'(pop ? count - 1'b1 : count);
   end

   // Fetch pointer, shifting queue and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= 32'(RESET_PC);
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_word[i] <= '0;
         end
      end else if (flush) begin
         fetch_pc <= {branch_target[31:2], 2'b00};
         count    <= '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               q_pc[i]   <= q_pc[i+1];
               q_word[i] <= q_word[i+1];
            end
         end
         if (push) begin
            q_pc[wr_idx]   <= fetch_pc;
            q_word[wr_idx] <= mem_read_data;
            fetch_pc       <= fetch_pc + 32'd4;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

endmodule
